// File: rtl/spike_event_encoder.sv
// Spike event encoder: captures per-neuron adder results, writes potentials
// back to memory, turns first-time spikes into {cluster, neuron} packets,
// queues them in a small FIFO and signals when a timestep has fully drained.
module spike_event_encoder #(
  parameter int NEURON_COUNT     = 16,
  parameter int ID_WIDTH         = 4,
  parameter int CLUSTER_ID       = 0,
  parameter int CLUSTER_ID_WIDTH = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 timestep_clear,
  input  logic                                 timestep_end,
  input  logic                                 neuron_valid,
  input  logic [ID_WIDTH-1:0]                  neuron_id,
  input  logic                                 spike_in,
  input  logic [31:0]                          final_potential,
  output logic                                 pot_wr_en,
  output logic [ID_WIDTH-1:0]                  pot_wr_addr,
  output logic [31:0]                          pot_wr_data,
  output logic                                 pkt_valid,
  output logic [CLUSTER_ID_WIDTH+ID_WIDTH-1:0] pkt_data,
  input  logic                                 pkt_ready,
  output logic [ID_WIDTH:0]                    spike_count,
  output logic                                 overflow,
  output logic                                 timestep_done
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int PKT_W = CLUSTER_ID_WIDTH + ID_WIDTH;
  // Bitmap covers every encodable id so indexing never goes out of range;
  // ids at or above NEURON_COUNT are filtered before they touch it.
  localparam int BM_W  = 1 << ID_WIDTH;

  localparam logic [ID_WIDTH:0]           NC      = NEURON_COUNT[ID_WIDTH:0];
  localparam logic [CW-1:0]               DEPTH_C = FIFO_DEPTH[CW-1:0];
  localparam logic [CLUSTER_ID_WIDTH-1:0] CID     = CLUSTER_ID[CLUSTER_ID_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [BM_W-1:0]       bitmap_q, bitmap_d;
  logic [ID_WIDTH:0]     spike_count_q, spike_count_d;
  logic                  overflow_q, overflow_d;
  logic                  timestep_done_q, timestep_done_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pot_wr_en_q, pot_wr_en_d;
  logic [ID_WIDTH-1:0]   pot_wr_addr_q, pot_wr_addr_d;
  logic [31:0]           pot_wr_data_q, pot_wr_data_d;
  logic [PKT_W-1:0]      mem_q [FIFO_DEPTH];

  logic                  in_range;
  logic                  accept;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_full;
  logic [PKT_W-1:0]      pkt_word;

  // Acceptance, FIFO bookkeeping and next-state computation.
  always_comb begin
    in_range  = ({1'b0, neuron_id} < NC);
    // Results are only taken while collecting; the cycle carrying
    // timestep_end is still COLLECT, so the last result is included.
    accept    = neuron_valid && in_range && (state_q == COLLECT) && !timestep_clear;
    push_req  = accept && spike_in && !bitmap_q[neuron_id];
    // A flush wins over a pop: the head presented that cycle is discarded.
    pop       = (count_q != '0) && pkt_ready && !timestep_clear;
    fifo_full = (count_q == DEPTH_C);
    push_ok   = push_req && (!fifo_full || pop);
    pkt_word  = {CID, neuron_id};

    state_d         = state_q;
    bitmap_d        = bitmap_q;
    spike_count_d   = spike_count_q;
    overflow_d      = overflow_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    pot_wr_en_d     = accept;
    pot_wr_addr_d   = accept ? neuron_id : pot_wr_addr_q;
    pot_wr_data_d   = accept ? final_potential : pot_wr_data_q;

    if (timestep_clear) begin
      bitmap_d      = '0;
      spike_count_d = '0;
      overflow_d    = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      state_d       = COLLECT;
    end else begin
      // A dropped spike still counts as seen, so it is not re-sent later.
      if (push_req) begin
        bitmap_d[neuron_id] = 1'b1;
        if (spike_count_q != NC) begin
          spike_count_d = spike_count_q + (ID_WIDTH+1)'(1);
        end
      end
      if (push_req && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (timestep_end) state_d = DRAIN;
        // No pushes happen outside COLLECT, so an empty next count means drained.
        DRAIN:   if (count_d == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    timestep_done_d = (state_d == DONE);
  end

  // Control, status and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bitmap_q        <= '0;
      spike_count_q   <= '0;
      overflow_q      <= 1'b0;
      timestep_done_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      pot_wr_en_q     <= 1'b0;
      pot_wr_addr_q   <= '0;
      pot_wr_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      bitmap_q        <= bitmap_d;
      spike_count_q   <= spike_count_d;
      overflow_q      <= overflow_d;
      timestep_done_q <= timestep_done_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      pot_wr_en_q     <= pot_wr_en_d;
      pot_wr_addr_q   <= pot_wr_addr_d;
      pot_wr_data_q   <= pot_wr_data_d;
    end
  end

  // Packet storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= pkt_word;
    end
  end

  assign pot_wr_en     = pot_wr_en_q;
  assign pot_wr_addr   = pot_wr_addr_q;
  assign pot_wr_data   = pot_wr_data_q;
  assign pkt_valid     = (count_q != '0);
  // Head is read straight from storage flops and forced to zero when empty,
  // so it is stable while held and clears immediately on reset.
  assign pkt_data      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign spike_count   = spike_count_q;
  assign overflow      = overflow_q;
  assign timestep_done = timestep_done_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder with hand-computed expectations.
module tb_spike_event_encoder;

  logic        clk;
  logic        rst_n;
  logic        timestep_clear;
  logic        timestep_end;
  logic        neuron_valid;
  logic [3:0]  neuron_id;
  logic        spike_in;
  logic [31:0] final_potential;
  logic        pot_wr_en;
  logic [3:0]  pot_wr_addr;
  logic [31:0] pot_wr_data;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic        pkt_ready;
  logic [4:0]  spike_count;
  logic        overflow;
  logic        timestep_done;

  int checks   = 0;
  int failures = 0;

  spike_event_encoder #(
    .NEURON_COUNT(16), .ID_WIDTH(4), .CLUSTER_ID(0),
    .CLUSTER_ID_WIDTH(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .timestep_clear(timestep_clear), .timestep_end(timestep_end),
    .neuron_valid(neuron_valid), .neuron_id(neuron_id),
    .spike_in(spike_in), .final_potential(final_potential),
    .pot_wr_en(pot_wr_en), .pot_wr_addr(pot_wr_addr), .pot_wr_data(pot_wr_data),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .spike_count(spike_count), .overflow(overflow), .timestep_done(timestep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic sp, input logic [31:0] pot);
    neuron_valid    = 1'b1;
    neuron_id       = 4'(id);
    spike_in        = sp;
    final_potential = pot;
  endtask

  task automatic pulse_clear();
    timestep_clear = 1'b1;
    tick();
    timestep_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; timestep_clear = 1'b0; timestep_end = 1'b0;
    neuron_valid = 1'b0; neuron_id = '0; spike_in = 1'b0;
    final_potential = '0; pkt_ready = 1'b0;
    tick(); tick();
    check_eq("rst_pot_wr_en", 32'(pot_wr_en), 0);
    check_eq("rst_pkt_valid", 32'(pkt_valid), 0);
    check_eq("rst_pkt_data", 32'(pkt_data), 0);
    check_eq("rst_spike_count", 32'(spike_count), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_done", 32'(timestep_done), 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-transfer with three packets queued.
    pulse_clear();
    for (int i = 1; i <= 3; i++) begin
      drive(i, 1'b1, 32'h1000 + i);
      tick();
    end
    neuron_valid = 1'b0;
    check_eq("a_pkt_valid", 32'(pkt_valid), 1);
    check_eq("a_spike_count", 32'(spike_count), 3);
    check_eq("a_pot_wr_en", 32'(pot_wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("a_async_pot_wr_en", 32'(pot_wr_en), 0);
    check_eq("a_async_pkt_valid", 32'(pkt_valid), 0);
    check_eq("a_async_pkt_data", 32'(pkt_data), 0);
    check_eq("a_async_spike_count", 32'(spike_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("a_post_pkt_valid", 32'(pkt_valid), 0);
    $display("tx: reset mid-transfer done");

    // Two results, one spike; downstream always ready.
    pkt_ready = 1'b1;
    pulse_clear();
    drive(2, 1'b1, 32'h3F800000);
    tick();
    check_eq("b_wr_en0", 32'(pot_wr_en), 1);
    check_eq("b_wr_addr0", 32'(pot_wr_addr), 2);
    check_eq("b_wr_data0", pot_wr_data, 32'h3F800000);
    check_eq("b_pkt_valid", 32'(pkt_valid), 1);
    check_eq("b_pkt_data", 32'(pkt_data), 32'h02);
    check_eq("b_spike_count", 32'(spike_count), 1);
    drive(5, 1'b0, 32'h40000000);
    tick();
    check_eq("b_wr_en1", 32'(pot_wr_en), 1);
    check_eq("b_wr_addr1", 32'(pot_wr_addr), 5);
    check_eq("b_wr_data1", pot_wr_data, 32'h40000000);
    check_eq("b_popped", 32'(pkt_valid), 0);
    check_eq("b_spike_count1", 32'(spike_count), 1);
    neuron_valid = 1'b0;
    tick();
    check_eq("b_wr_en_idle", 32'(pot_wr_en), 0);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    check_eq("b_done_drain", 32'(timestep_done), 0);
    tick();
    check_eq("b_done_pulse", 32'(timestep_done), 1);
    tick();
    check_eq("b_done_low", 32'(timestep_done), 0);
    $display("tx: two results one packet done");

    // Results in IDLE are ignored.
    drive(4, 1'b1, 32'h1234);
    tick();
    neuron_valid = 1'b0;
    check_eq("idle_wr_en", 32'(pot_wr_en), 0);
    check_eq("idle_pkt_valid", 32'(pkt_valid), 0);

    // Repeat spike from neuron 7.
    pkt_ready = 1'b0;
    pulse_clear();
    drive(7, 1'b1, 32'hAAAA0000);
    tick();
    drive(7, 1'b1, 32'hBBBB0000);
    tick();
    neuron_valid = 1'b0;
    check_eq("c_wr_en", 32'(pot_wr_en), 1);
    check_eq("c_wr_data", pot_wr_data, 32'hBBBB0000);
    check_eq("c_spike_count", 32'(spike_count), 1);
    check_eq("c_pkt_data", 32'(pkt_data), 32'h07);
    pkt_ready = 1'b1;
    tick();
    check_eq("c_single_pkt", 32'(pkt_valid), 0);
    $display("tx: repeat spike suppressed done");

    // Overflow: nine spikes into eight entries.
    pkt_ready = 1'b0;
    pulse_clear();
    for (int i = 0; i <= 8; i++) begin
      drive(i, 1'b1, 32'(i));
      tick();
      if (i == 7) check_eq("d_no_ovf_at_full", 32'(overflow), 0);
    end
    neuron_valid = 1'b0;
    check_eq("d_overflow", 32'(overflow), 1);
    check_eq("d_spike_count", 32'(spike_count), 9);
    pkt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("d_pkt_valid", 32'(pkt_valid), 1);
      check_eq("d_pkt_order", 32'(pkt_data), 32'(k));
      $display("tx: pkt 0x%02h", pkt_data);
      tick();
    end
    check_eq("d_empty", 32'(pkt_valid), 0);

    // Drain with toggling ready; last result carries timestep_end.
    pkt_ready = 1'b0;
    pulse_clear();
    drive(3, 1'b1, 32'h3);
    tick();
    drive(4, 1'b1, 32'h4);
    tick();
    drive(5, 1'b1, 32'h5);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    drive(9, 1'b1, 32'h9);
    check_eq("e_spike_count", 32'(spike_count), 3);
    pkt_ready = 1'b1;
    check_eq("e_head0", 32'(pkt_data), 32'h03);
    tick();
    check_eq("e_drain_wr_en", 32'(pot_wr_en), 0);
    check_eq("e_done0", 32'(timestep_done), 0);
    pkt_ready = 1'b0;
    tick();
    check_eq("e_head1", 32'(pkt_data), 32'h04);
    check_eq("e_done1", 32'(timestep_done), 0);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    tick();
    check_eq("e_head2", 32'(pkt_data), 32'h05);
    check_eq("e_done2", 32'(timestep_done), 0);
    pkt_ready = 1'b1;
    tick();
    check_eq("e_done_pulse", 32'(timestep_done), 1);
    check_eq("e_empty", 32'(pkt_valid), 0);
    check_eq("e_spike_count_end", 32'(spike_count), 3);
    pkt_ready = 1'b0;
    tick();
    check_eq("e_done_low", 32'(timestep_done), 0);
    check_eq("e_no_wr", 32'(pot_wr_en), 0);
    neuron_valid = 1'b0;
    $display("tx: drain handshake done");

    // Clear during DRAIN with two entries left.
    pulse_clear();
    for (int i = 0; i <= 8; i++) begin
      drive(i, 1'b1, 32'(i));
      tick();
    end
    neuron_valid = 1'b0;
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    pkt_ready = 1'b1;
    repeat (6) tick();
    check_eq("f_pkt_valid", 32'(pkt_valid), 1);
    check_eq("f_head", 32'(pkt_data), 32'h06);
    check_eq("f_overflow", 32'(overflow), 1);
    timestep_clear = 1'b1;
    tick();
    timestep_clear = 1'b0;
    check_eq("f_flushed", 32'(pkt_valid), 0);
    check_eq("f_ovf_clr", 32'(overflow), 0);
    check_eq("f_cnt_clr", 32'(spike_count), 0);
    pkt_ready = 1'b0;
    drive(3, 1'b1, 32'h33);
    tick();
    neuron_valid = 1'b0;
    check_eq("f_new_valid", 32'(pkt_valid), 1);
    check_eq("f_new_pkt", 32'(pkt_data), 32'h03);
    check_eq("f_new_cnt", 32'(spike_count), 1);
    $display("tx: clear during drain done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
